// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: command and status bundle between fetch control and the PC sequencer
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = 6,
    parameter int OFF_WIDTH   = 6,
    parameter int STACK_DEPTH = 4
);
    localparam int SP_WIDTH = $clog2(STACK_DEPTH + 1);
    logic                 en;
    logic                 jump;
    logic [PC_WIDTH-1:0]  jump_addr;
    logic                 branch;
    logic [OFF_WIDTH-1:0] branch_off;
    logic                 call;
    logic [PC_WIDTH-1:0]  call_addr;
    logic                 ret;
    logic                 err_clr;
    logic [PC_WIDTH-1:0]  count;
    logic [PC_WIDTH-1:0]  pc_next;
    logic [SP_WIDTH-1:0]  sp;
    logic                 stack_ovf;
    logic                 stack_unf;
    modport master (
        output en, jump, jump_addr, branch, branch_off, call, call_addr, ret, err_clr,
        input  count, pc_next, sp, stack_ovf, stack_unf
    );
    modport slave (
        input  en, jump, jump_addr, branch, branch_off, call, call_addr, ret, err_clr,
        output count, pc_next, sp, stack_ovf, stack_unf
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC with stall, jump, relative branch and call/return stack
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 6,
    parameter int                  OFF_WIDTH   = 6,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  STACK_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    pc_sequencer_if.slave   bus
);
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int AW  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
    logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
    logic [PC_WIDTH-1:0] count, inc, br, top, nxt;
    logic [PC_WIDTH-1:0] off_ext;
    logic [SPW-1:0]      sp;
    logic [AW-1:0]       rd_idx, wr_idx;
    logic                full, empty, pop, push, ovf_set, unf_set, ovf, unf;
    assign off_ext = PC_WIDTH'($signed(bus.branch_off));
    assign inc     = count + PC_WIDTH'(1);
    assign br      = count + off_ext;
    assign full    = sp == SPW'(STACK_DEPTH);
    assign empty   = sp == '0;
    assign rd_idx  = AW'(sp - SPW'(1));
    assign wr_idx  = AW'(sp);
    assign top     = stack[rd_idx];
    assign pop     = bus.en & bus.ret & ~empty;
    assign push    = bus.en & ~bus.ret & bus.call & ~full;
    assign ovf_set = bus.en & ~bus.ret & bus.call & full;
    assign unf_set = bus.en & bus.ret & empty;
    // ret on an empty stack degrades to a plain increment
    always_comb
        nxt = bus.ret    ? (empty ? inc : top) :
              bus.call   ? bus.call_addr :
              bus.jump   ? bus.jump_addr :
              bus.branch ? br : inc;
    assign bus.pc_next   = rst ? nxt : inc;
    assign bus.count     = count;
    assign bus.sp        = sp;
    assign bus.stack_ovf = ovf;
    assign bus.stack_unf = unf;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            count <= RESET_PC;
            sp    <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (bus.en) count <= nxt;
            sp  <= push ? sp + SPW'(1) : pop ? sp - SPW'(1) : sp;
            ovf <= ovf_set | (ovf & ~bus.err_clr);
            unf <= unf_set | (unf & ~bus.err_clr);
        end
    // storage is unreset; sp alone marks which entries are live
    always_ff @(posedge clk)
        if (rst && push) stack[wr_idx] <= inc;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table vectors plus random commands checked against a queue-based PC model
module tb_pc_sequencer;
    localparam int W = 6, D = 4, M = 64;
    logic clk = 0, rst = 0;
    pc_sequencer_if #(.PC_WIDTH(W), .OFF_WIDTH(W), .STACK_DEPTH(D)) bus ();
    pc_sequencer #(.PC_WIDTH(W), .OFF_WIDTH(W), .RESET_PC('0), .STACK_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct { bit en, jump; int ja; bit br; int off; bit call; int ca; bit ret, clr; } cmd_t;
    typedef struct { cmd_t c; int cnt, sp; bit ovf, unf; } vec_t;

    int n_chk = 0, n_fail = 0;
    int m_pc;
    int m_stk[$];
    bit m_ovf, m_unf;
    vec_t vecs[$];

    function automatic cmd_t mk(bit en, bit j, int ja, bit b, int off, bit c, int ca, bit r, bit clr);
        cmd_t x;
        x.en = en; x.jump = j; x.ja = ja; x.br = b; x.off = off;
        x.call = c; x.ca = ca; x.ret = r; x.clr = clr;
        return x;
    endfunction

    function automatic int wrap(int x);
        return ((x % M) + M) % M;
    endfunction

    function automatic int model_next(cmd_t c);
        if (c.ret) return m_stk.size() > 0 ? m_stk[m_stk.size()-1] : wrap(m_pc + 1);
        if (c.call) return c.ca;
        if (c.jump) return c.ja;
        if (c.br) return wrap(m_pc + c.off);
        return wrap(m_pc + 1);
    endfunction

    task automatic model_apply(cmd_t c);
        int nxt;
        bit os, us;
        nxt = model_next(c);
        os = 0; us = 0;
        if (c.en) begin
            if (c.ret) begin
                if (m_stk.size() > 0) void'(m_stk.pop_back());
                else us = 1;
            end else if (c.call) begin
                if (m_stk.size() < D) m_stk.push_back(wrap(m_pc + 1));
                else os = 1;
            end
            m_pc = nxt;
        end
        m_ovf = os | (m_ovf & !c.clr);
        m_unf = us | (m_unf & !c.clr);
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_state(string tag, int cnt, int sp, bit ovf, bit unf);
        check({tag, " count"}, 32'(bus.count), cnt);
        check({tag, " sp"}, 32'(bus.sp), sp);
        check({tag, " ovf"}, 32'(bus.stack_ovf), 32'(ovf));
        check({tag, " unf"}, 32'(bus.stack_unf), 32'(unf));
    endtask

    task automatic drive(cmd_t c);
        bus.en = c.en; bus.jump = c.jump; bus.jump_addr = W'(c.ja);
        bus.branch = c.br; bus.branch_off = W'(c.off);
        bus.call = c.call; bus.call_addr = W'(c.ca);
        bus.ret = c.ret; bus.err_clr = c.clr;
    endtask

    task automatic apply(cmd_t c);
        @(negedge clk);
        drive(c);
        #1 check("pc_next", 32'(bus.pc_next), model_next(c));
        @(posedge clk);
        model_apply(c);
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        drive(mk(1, 1, 40, 0, 0, 0, 0, 0, 0));
        #2 rst = 0;
        #1 check_state("async_rst", 0, 0, 0, 0);
        check("async_rst pc_next", 32'(bus.pc_next), 1);
        model_reset();
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1;
    endtask

    task automatic add(cmd_t c, int cnt, int sp, bit ovf, bit unf);
        vec_t v;
        v.c = c; v.cnt = cnt; v.sp = sp; v.ovf = ovf; v.unf = unf;
        vecs.push_back(v);
    endtask

    initial begin
        add(mk(1, 1, 10, 0,  0, 0,  0, 0, 0), 10, 0, 0, 0);
        add(mk(1, 0,  0, 1, -3, 0,  0, 0, 0),  7, 0, 0, 0);
        add(mk(1, 1, 62, 0,  0, 0,  0, 0, 0), 62, 0, 0, 0);
        add(mk(1, 0,  0, 1,  5, 0,  0, 0, 0),  3, 0, 0, 0);
        add(mk(1, 0,  0, 1,  0, 0,  0, 0, 0),  3, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(mk(0, 1, 40, 0, 0, 0, 0, 0, 0), 3, 0, 0, 0);
        add(mk(1, 1, 40, 0,  0, 0,  0, 0, 0), 40, 0, 0, 0);
        add(mk(1, 1,  5, 0,  0, 0,  0, 0, 0),  5, 0, 0, 0);
        add(mk(1, 0,  0, 0,  0, 1, 20, 0, 0), 20, 1, 0, 0);
        add(mk(1, 0,  0, 0,  0, 1, 30, 0, 0), 30, 2, 0, 0);
        add(mk(1, 0,  0, 0,  0, 1, 40, 0, 0), 40, 3, 0, 0);
        add(mk(1, 0,  0, 0,  0, 1, 50, 0, 0), 50, 4, 0, 0);
        add(mk(1, 0,  0, 0,  0, 1, 60, 0, 0), 60, 4, 1, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0), 41, 3, 1, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0), 31, 2, 1, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0), 21, 1, 1, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0),  6, 0, 1, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0),  7, 0, 1, 1);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 1),  8, 0, 0, 1);
        add(mk(1, 0,  0, 0,  0, 0,  0, 0, 1),  9, 0, 0, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0), 10, 0, 0, 1);
        add(mk(0, 0,  0, 0,  0, 0,  0, 0, 1), 10, 0, 0, 0);
        add(mk(1, 1, 11, 0,  0, 0,  0, 0, 0), 11, 0, 0, 0);
        add(mk(1, 0,  0, 0,  0, 1, 33, 0, 0), 33, 1, 0, 0);
        add(mk(1, 1, 20, 0,  0, 1, 50, 1, 0), 12, 0, 0, 0);
        add(mk(1, 1, 25, 1,  3, 0,  0, 0, 0), 25, 0, 0, 0);
        add(mk(1, 0,  0, 1, -1, 0,  0, 0, 0), 24, 0, 0, 0);
        add(mk(1, 1,  7, 1, 10, 1,  3, 0, 0),  3, 1, 0, 0);
        add(mk(0, 0,  0, 0,  0, 0,  0, 1, 0),  3, 1, 0, 0);
        add(mk(1, 0,  0, 0,  0, 0,  0, 1, 0), 25, 0, 0, 0);

        drive(mk(1, 1, 40, 0, 0, 0, 0, 0, 0));
        model_reset();
        #3 check_state("reset", 0, 0, 0, 0);
        check("reset pc_next", 32'(bus.pc_next), 1);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1;

        for (int i = 0; i < 70; i++) begin
            apply(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
            check_state($sformatf("inc%0d", i), m_pc, 0, 0, 0);
        end
        check("inc final count", 32'(bus.count), 6);

        async_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].c);
            check_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].sp, vecs[i].ovf, vecs[i].unf);
        end

        for (int i = 0; i < 400; i++) begin
            cmd_t c;
            c = mk($urandom_range(99) < 90, $urandom_range(99) < 15, int'($urandom_range(M-1)),
                   $urandom_range(99) < 25, int'($urandom_range(M-1)) - M/2,
                   $urandom_range(99) < 25, int'($urandom_range(M-1)),
                   $urandom_range(99) < 25, $urandom_range(99) < 8);
            apply(c);
            check_state($sformatf("rnd%0d", i), m_pc, m_stk.size(), m_ovf, m_unf);
        end

        apply(mk(1, 0, 0, 0, 0, 1, 9, 0, 0));
        check_state("pre_rst", m_pc, m_stk.size(), m_ovf, m_unf);
        async_reset();
        apply(mk(1, 0, 0, 0, 0, 0, 0, 1, 0));
        check_state("post_rst ret", 1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
